// File: rtl/branch_resolve_unit.sv
// Branch resolution: in-order FIFO of fetch-time predictions checked against decode outcomes,
// producing mispredict redirect/flush and BHT training. Optional counters: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int INDEX_WIDTH = 10,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   push_valid,
    input  logic [31:0]            push_pc,
    input  logic                   push_taken,
    input  logic [31:0]            push_target,
    output logic                   full,
    input  logic                   res_valid,
    input  logic [31:0]            res_pc,
    input  logic                   res_taken,
    input  logic [31:0]            res_target,
    output logic                   miss,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   flush,
    output logic                   update_en,
    output logic [INDEX_WIDTH-1:0] update_index,
    output logic                   update_taken
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]            perf_branches,
    output logic [31:0]            perf_misses
`endif
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } state_t;

    state_t state_q;

    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic [PW:0]   wr_ptr_d;
    logic [PW:0]   rd_ptr_d;

    logic [31:0]   pc_mem     [DEPTH];
    logic          taken_mem  [DEPTH];
    logic [31:0]   target_mem [DEPTH];

    logic                   redirect_valid_q;
    logic [31:0]            redirect_pc_q;
    logic                   flush_q;
    logic                   update_en_q;
    logic [INDEX_WIDTH-1:0] update_index_q;
    logic                   update_taken_q;

    logic        empty;
    logic        run;
    logic        resolve;
    logic        pop;
    logic        push;
    logic        take_miss;
    logic [31:0] head_pc;
    logic        head_taken;
    logic [31:0] head_target;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign head_pc     = pc_mem[rd_ptr_q[PW-1:0]];
    assign head_taken  = taken_mem[rd_ptr_q[PW-1:0]];
    assign head_target = target_mem[rd_ptr_q[PW-1:0]];

    assign miss = res_valid & (empty | (head_pc != res_pc) | (head_taken != res_taken)
                               | (res_taken & (head_target != res_target)));

    assign run       = (state_q == ST_RUN);
    assign resolve   = en & res_valid & run;
    assign pop       = resolve & ~empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is accepted then.
    assign push      = en & push_valid & run & (~full | pop);
    assign take_miss = resolve & miss;

    assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q[PW-1:0]]     <= push_pc;
            taken_mem[wr_ptr_q[PW-1:0]]  <= push_taken;
            target_mem[wr_ptr_q[PW-1:0]] <= push_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            update_en_q      <= 1'b0;
            update_index_q   <= '0;
            update_taken_q   <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            update_en_q      <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_RUN: begin
                        wr_ptr_q <= wr_ptr_d;
                        rd_ptr_q <= rd_ptr_d;
                        if (resolve) begin
                            update_en_q    <= 1'b1;
                            update_index_q <= res_pc[INDEX_WIDTH+1:2];
                            update_taken_q <= res_taken;
                        end
                        // Everything younger than a mispredicted branch is wrong-path.
                        if (take_miss) begin
                            state_q          <= ST_REDIRECT;
                            wr_ptr_q         <= '0;
                            rd_ptr_q         <= '0;
                            redirect_valid_q <= 1'b1;
                            flush_q          <= 1'b1;
                            redirect_pc_q    <= res_taken ? res_target : res_pc + 32'd4;
                        end
                    end
                    ST_REDIRECT: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign update_en      = update_en_q;
    assign update_index   = update_index_q;
    assign update_taken   = update_taken_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q <= '0;
            perf_misses_q   <= '0;
        end else begin
            if (resolve) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if (take_miss) begin
                perf_misses_q <= perf_misses_q + 32'd1;
            end
        end
    end

    assign perf_branches = perf_branches_q;
    assign perf_misses   = perf_misses_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases followed by random traffic,
// checked against a queue-based model of the prediction records.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int IW    = 10;

    logic          clk;
    logic          rst;
    logic          en;
    logic          push_valid;
    logic [31:0]   push_pc;
    logic          push_taken;
    logic [31:0]   push_target;
    logic          full;
    logic          res_valid;
    logic [31:0]   res_pc;
    logic          res_taken;
    logic [31:0]   res_target;
    logic          miss;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic          update_en;
    logic [IW-1:0] update_index;
    logic          update_taken;

    branch_resolve_unit #(.INDEX_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .push_valid     (push_valid),
        .push_pc        (push_pc),
        .push_taken     (push_taken),
        .push_target    (push_target),
        .full           (full),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .miss           (miss),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .update_en      (update_en),
        .update_index   (update_index),
        .update_taken   (update_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } rec_t;

    typedef struct {
        int          due;
        logic [31:0] idx;
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    rec_t model_q[$];
    bit   model_redir;
    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   started;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock of stimulus; the model advances by the architectural rules.
    task automatic step(input bit r, input bit e,
                        input bit pv, input logic [31:0] ppc, input bit pt, input logic [31:0] ptg,
                        input bit rv, input logic [31:0] rpc_i, input bit rt, input logic [31:0] rtg);
        bit   exp_miss;
        rec_t hd;
        exp_t ex;
        rec_t nr;
        @(negedge clk);
        rst = r; en = e;
        push_valid = pv; push_pc = ppc; push_taken = pt; push_target = ptg;
        res_valid = rv; res_pc = rpc_i; res_taken = rt; res_target = rtg;
        #1;
        exp_miss = 1'b0;
        if (rv) begin
            if (model_q.size() == 0) begin
                exp_miss = 1'b1;
            end else begin
                hd = model_q[0];
                exp_miss = (hd.pc != rpc_i) || (hd.taken != rt) || (rt && hd.target != rtg);
            end
        end
        chk("miss", {31'd0, miss}, {31'd0, exp_miss});
        chk("full", {31'd0, full}, {31'd0, model_q.size() == DEPTH});
        if (r) begin
            model_q.delete();
            model_redir = 1'b0;
        end else if (e) begin
            if (model_redir) begin
                model_redir = 1'b0;
            end else begin
                if (rv) begin
                    ex.due   = cyc + 1;
                    ex.idx   = {22'd0, rpc_i[IW+1:2]};
                    ex.taken = rt;
                    ex.redir = exp_miss;
                    ex.rpc   = rt ? rtg : rpc_i + 32'd4;
                    sb.push_back(ex);
                    if (model_q.size() > 0) void'(model_q.pop_front());
                end
                if (pv && model_q.size() < DEPTH) begin
                    nr.pc = ppc; nr.taken = pt; nr.target = ptg;
                    model_q.push_back(nr);
                end
                if (rv && exp_miss) begin
                    model_q.delete();
                    model_redir = 1'b1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_push(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        step(0, 1, 1, pc, t, tg, 0, 0, 0, 0);
    endtask

    task automatic do_res(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        step(0, 1, 0, 0, 0, 0, 1, pc, t, tg);
    endtask

    task automatic chk_all_zero();
        #2;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_update_en", {31'd0, update_en}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_update_index", {22'd0, update_index}, 32'd0);
        chk("rst_update_taken", {31'd0, update_taken}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a training pulse.
    always @(posedge clk) begin
        exp_t ex;
        #1;
        cyc++;
        if (started) begin
            if (update_en === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("update_en_spurious", {31'd0, update_en}, 32'd0);
                end else begin
                    ex = sb.pop_front();
                    chk("update_index", {22'd0, update_index}, ex.idx);
                    chk("update_taken", {31'd0, update_taken}, {31'd0, ex.taken});
                    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, ex.redir});
                    chk("flush", {31'd0, flush}, {31'd0, ex.redir});
                    if (ex.redir) chk("redirect_pc", redirect_pc, ex.rpc);
                end
            end else begin
                chk("redirect_valid_idle", {31'd0, redirect_valid}, 32'd0);
                chk("flush_idle", {31'd0, flush}, 32'd0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("update_en_due", {31'd0, update_en}, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rec_t        hd;
        logic [31:0] a_pc, a_tg, r_pc, r_tg;
        bit          a_t, r_t, a_v, r_v, a_e, a_r;
        n_checks = 0; n_fail = 0; cyc = 0; started = 0; model_redir = 0;
        rst = 1; en = 0; push_valid = 0; push_pc = 0; push_taken = 0; push_target = 0;
        res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
        repeat (2) @(posedge clk);
        chk_all_zero();
        started = 1;
        @(negedge clk);
        rst = 0;
        idle();

        do_push(32'h100, 1, 32'h200);
        do_res(32'h100, 1, 32'h200);
        idle();

        do_push(32'h104, 0, 32'h0);
        do_res(32'h104, 1, 32'h300);
        idle();

        do_push(32'h200, 1, 32'h400);
        do_push(32'h204, 1, 32'h404);
        do_push(32'h208, 0, 32'h0);
        do_res(32'h200, 1, 32'h444);
        do_push(32'h20c, 1, 32'h500);
        do_res(32'h20c, 1, 32'h500);
        idle();

        for (int i = 0; i < DEPTH + 1; i++) do_push(32'h300 + 32'(4 * i), i[0], 32'h600 + 32'(i));
        step(0, 1, 1, 32'h340, 1, 32'h700, 1, 32'h300, 0, 32'h600);
        for (int i = 1; i < DEPTH; i++) do_res(32'h300 + 32'(4 * i), i[0], 32'h600 + 32'(i));
        do_res(32'h340, 1, 32'h700);
        idle();

        do_res(32'h180, 0, 32'h0);
        idle();

        do_push(32'h440, 1, 32'h880);
        step(0, 0, 1, 32'h444, 0, 0, 1, 32'h440, 1, 32'h880);
        do_res(32'h440, 1, 32'h880);
        idle();

        do_res(32'h180, 0, 32'h0);
        step(1, 1, 1, 32'h999, 1, 32'h0, 1, 32'h4, 0, 0);
        chk_all_zero();
        do_push(32'h500, 0, 32'h0);
        do_res(32'h500, 0, 32'h0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            a_r  = ($urandom_range(0, 199) == 0);
            a_e  = ($urandom_range(0, 9) != 0);
            a_v  = $urandom_range(0, 1) != 0;
            a_pc = 32'h1000 + ($urandom_range(0, 1023) << 2);
            a_t  = $urandom_range(0, 1) != 0;
            a_tg = 32'h8000 + ($urandom_range(0, 1023) << 2);
            r_v  = $urandom_range(0, 1) != 0;
            if (model_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                hd   = model_q[0];
                r_pc = hd.pc; r_t = hd.taken; r_tg = hd.target;
                if (!r_t) r_tg = $urandom;
                if ($urandom_range(0, 7) == 0) r_tg = r_tg ^ 32'h10;
            end else begin
                r_pc = 32'h1000 + ($urandom_range(0, 1023) << 2);
                r_t  = $urandom_range(0, 1) != 0;
                r_tg = 32'h8000 + ($urandom_range(0, 1023) << 2);
            end
            step(a_r, a_e, a_v, a_pc, a_t, a_tg, r_v, r_pc, r_t, r_tg);
        end

        repeat (3) idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
